// File: rtl/signal_scramble_pkg.sv
// signal_scramble_pkg: shared FFT helpers.
//   fsm_state_e : reorder sequencer states (RUN/FLUSH/DONE)
//   addr_w()    : address width covering the in-place working memory
//                 (input half + output half = 2*FFT_SIZE words)
//   bit_rev()   : reverse the low 'bits' bits of n
// Build option: SCRAMBLE_BYPASS_EN turns bit_rev() into identity
// (masked to 'bits'), giving a straight lower->upper copy.
package signal_scramble_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } fsm_state_e;

  function automatic int addr_w(input int fft_size);
    return $clog2(2 * fft_size);
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] n, input int bits);
    logic [31:0] r;
    r = '0;
`ifdef SCRAMBLE_BYPASS_EN
    r = n & ((32'd1 << bits) - 32'd1);
`else
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[i] = n[bits-1-i];
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/signal_scramble_if.sv
// signal_scramble_if: memory-side bus of the reorder stage.
//   master : the scramble core (drives read/write requests, takes read data)
//   slave  : the memory side (takes requests, returns read data)
// Signal names follow the core's port naming (o_* driven by the core).
interface signal_scramble_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 4
);
  logic                 o_rden;
  logic                 o_wren;
  logic [ADDR_SIZE-1:0] o_rdaddr_A;
  logic [ADDR_SIZE-1:0] o_rdaddr_B;
  logic [ADDR_SIZE-1:0] o_wraddr_A;
  logic [ADDR_SIZE-1:0] o_wraddr_B;
  logic [WORD_SIZE-1:0] o_wrdata_A;
  logic [WORD_SIZE-1:0] o_wrdata_B;
  logic [WORD_SIZE-1:0] i_rddata_A;
  logic [WORD_SIZE-1:0] i_rddata_B;

  modport master (
    output o_rden, o_wren,
    output o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B,
    output o_wrdata_A, o_wrdata_B,
    input  i_rddata_A, i_rddata_B
  );

  modport slave (
    input  o_rden, o_wren,
    input  o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B,
    input  o_wrdata_A, o_wrdata_B,
    output i_rddata_A, i_rddata_B
  );
endinterface

// File: rtl/signal_scramble_ram2b.sv
// ram2b: dual-read / dual-write working memory for the FFT pipeline.
//   i_CLK            clock (the system drives it with inverted core clock)
//   i_RST            synchronous active-low reset; clears read registers only
//   i_rden_A/B       per-port read enables; read data is registered
//   i_rdaddr_A/B     read addresses
//   o_rddata_A/B     registered read data
//   i_wren_A/B       per-port write enables (B wins on same-address collision)
//   i_wraddr_A/B     write addresses
//   i_wrdata_A/B     write data
// The array itself is never reset, so contents survive a reset pulse.
module ram2b #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_rden_A,
  input  logic                 i_rden_B,
  input  logic [ADDR_SIZE-1:0] i_rdaddr_A,
  input  logic [ADDR_SIZE-1:0] i_rdaddr_B,
  output logic [WORD_SIZE-1:0] o_rddata_A,
  output logic [WORD_SIZE-1:0] o_rddata_B,
  input  logic                 i_wren_A,
  input  logic                 i_wren_B,
  input  logic [ADDR_SIZE-1:0] i_wraddr_A,
  input  logic [ADDR_SIZE-1:0] i_wraddr_B,
  input  logic [WORD_SIZE-1:0] i_wrdata_A,
  input  logic [WORD_SIZE-1:0] i_wrdata_B
);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] rddata_a_q, rddata_b_q;

  always_ff @(posedge i_CLK) begin
    if (i_wren_A) mem_q[i_wraddr_A] <= i_wrdata_A;
    if (i_wren_B) mem_q[i_wraddr_B] <= i_wrdata_B;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      rddata_a_q <= '0;
      rddata_b_q <= '0;
    end else begin
      if (i_rden_A) rddata_a_q <= mem_q[i_rdaddr_A];
      if (i_rden_B) rddata_b_q <= mem_q[i_rdaddr_B];
    end
  end

  assign o_rddata_A = rddata_a_q;
  assign o_rddata_B = rddata_b_q;

endmodule

// File: rtl/signal_scramble.sv
// signal_scramble: bit-reversal reorder stage at the head of the FFT.
// Streams FFT_SIZE words out of the lower memory half two per cycle and
// writes each into the upper half at FFT_SIZE + rev(index), then raises
// a sticky done flag.
//   i_CLK   rising-edge clock
//   i_RST   synchronous reset, active-low
//   o_done  reorder complete (sticky until reset)
//   bus     memory bus (read enable/addresses, write enable/addresses/data,
//           read data back); memory runs on inverted i_CLK so read data
//           requested on one edge is valid before the next.
// Build option: SCRAMBLE_BYPASS_EN makes placement a straight copy.
module signal_scramble
  import signal_scramble_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int FFT_SIZE  = 8,
  parameter int ADDR_SIZE = addr_w(FFT_SIZE)
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  output logic              o_done,
  signal_scramble_if.master bus
);

  localparam int LOG = $clog2(FFT_SIZE);
  // k needs only LOG-1 bits; LOG keeps it non-zero width at FFT_SIZE=2.
  localparam int KW  = LOG;
  localparam logic [KW-1:0] K_LAST = KW'(FFT_SIZE/2 - 1);
  localparam logic [ADDR_SIZE-1:0] UPPER = ADDR_SIZE'(FFT_SIZE);

  fsm_state_e           state_q;
  logic [KW-1:0]        k_q, k_d;
  // vld_pipe_q[0] = read issued this cycle, [1] = write stage valid
  logic [1:0]           vld_pipe_q;
  logic [ADDR_SIZE-1:0] rdaddr_a_q, rdaddr_b_q, rdaddr_a_d, rdaddr_b_d;
  logic [ADDR_SIZE-1:0] wraddr_a_q, wraddr_b_q, wraddr_a_d, wraddr_b_d;
  logic [WORD_SIZE-1:0] wrdata_a_q, wrdata_b_q;
  logic                 done_q;

  assign k_d        = k_q + 1'b1;
  assign rdaddr_a_d = ADDR_SIZE'({k_q, 1'b0});
  assign rdaddr_b_d = ADDR_SIZE'({k_q, 1'b1});
  // Write targets are derived from the read addresses registered last
  // cycle, so they line up with the read data arriving now.
  assign wraddr_a_d = UPPER | ADDR_SIZE'(bit_rev(32'(rdaddr_a_q), LOG));
  assign wraddr_b_d = UPPER | ADDR_SIZE'(bit_rev(32'(rdaddr_b_q), LOG));

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q    <= ST_RUN;
      k_q        <= '0;
      vld_pipe_q <= '0;
      rdaddr_a_q <= '0;
      rdaddr_b_q <= '0;
      wraddr_a_q <= '0;
      wraddr_b_q <= '0;
      wrdata_a_q <= '0;
      wrdata_b_q <= '0;
      done_q     <= 1'b0;
    end else begin
      vld_pipe_q[1] <= vld_pipe_q[0];
      // Write stage only advances behind a valid read; otherwise it holds.
      if (vld_pipe_q[0]) begin
        wraddr_a_q <= wraddr_a_d;
        wraddr_b_q <= wraddr_b_d;
        wrdata_a_q <= bus.i_rddata_A;
        wrdata_b_q <= bus.i_rddata_B;
      end
      case (state_q)
        ST_RUN: begin
          vld_pipe_q[0] <= 1'b1;
          rdaddr_a_q    <= rdaddr_a_d;
          rdaddr_b_q    <= rdaddr_b_d;
          k_q           <= k_d;
          if (k_q == K_LAST) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Last pair is in the write stage; no new reads.
          vld_pipe_q[0] <= 1'b0;
          state_q       <= ST_DONE;
        end
        ST_DONE: begin
          vld_pipe_q[0] <= 1'b0;
          done_q        <= 1'b1;
        end
        default: begin
          vld_pipe_q[0] <= 1'b0;
          state_q       <= ST_DONE;
        end
      endcase
    end
  end

  assign bus.o_rden     = vld_pipe_q[0];
  assign bus.o_wren     = vld_pipe_q[1];
  assign bus.o_rdaddr_A = rdaddr_a_q;
  assign bus.o_rdaddr_B = rdaddr_b_q;
  assign bus.o_wraddr_A = wraddr_a_q;
  assign bus.o_wraddr_B = wraddr_b_q;
  assign bus.o_wrdata_A = wrdata_a_q;
  assign bus.o_wrdata_B = wrdata_b_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_signal_scramble.sv
module tb_signal_scramble;

  localparam int W = 8;
  localparam int N = 8;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic done;
  logic ram_clk;

  always #5 clk = ~clk;
  assign ram_clk = ~clk;

  signal_scramble_if #(.WORD_SIZE(W), .ADDR_SIZE(A)) bus ();

  signal_scramble #(.WORD_SIZE(W), .FFT_SIZE(N), .ADDR_SIZE(A)) dut (
    .i_CLK (clk),
    .i_RST (rst_n),
    .o_done(done),
    .bus   (bus)
  );

  // Bench may take over the RAM ports to preload and inspect memory.
  logic         tb_mode, tb_rden, tb_wren;
  logic [A-1:0] tb_ra, tb_rb, tb_wa, tb_wb;
  logic [W-1:0] tb_da, tb_db;
  logic         m_rden, m_wren;
  logic [A-1:0] m_ra, m_rb, m_wa, m_wb;
  logic [W-1:0] m_da, m_db, ram_qa, ram_qb;

  assign m_rden = tb_mode ? tb_rden : bus.o_rden;
  assign m_wren = tb_mode ? tb_wren : bus.o_wren;
  assign m_ra   = tb_mode ? tb_ra   : bus.o_rdaddr_A;
  assign m_rb   = tb_mode ? tb_rb   : bus.o_rdaddr_B;
  assign m_wa   = tb_mode ? tb_wa   : bus.o_wraddr_A;
  assign m_wb   = tb_mode ? tb_wb   : bus.o_wraddr_B;
  assign m_da   = tb_mode ? tb_da   : bus.o_wrdata_A;
  assign m_db   = tb_mode ? tb_db   : bus.o_wrdata_B;
  assign bus.i_rddata_A = ram_qa;
  assign bus.i_rddata_B = ram_qb;

  ram2b #(.WORD_SIZE(W), .DEPTH(2*N), .ADDR_SIZE(A)) u_ram (
    .i_CLK     (ram_clk),
    .i_RST     (rst_n),
    .i_rden_A  (m_rden),
    .i_rden_B  (m_rden),
    .i_rdaddr_A(m_ra),
    .i_rdaddr_B(m_rb),
    .o_rddata_A(ram_qa),
    .o_rddata_B(ram_qb),
    .i_wren_A  (m_wren),
    .i_wren_B  (m_wren),
    .i_wraddr_A(m_wa),
    .i_wraddr_B(m_wb),
    .i_wrdata_A(m_da),
    .i_wrdata_B(m_db)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_up [8];
  logic [7:0] exp_wa [4];
  logic [7:0] exp_wb [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pair(input logic [A-1:0] a, input logic [W-1:0] da, input logic [W-1:0] db);
    tb_wren = 1'b1;
    tb_wa   = a;
    tb_wb   = a + 1'b1;
    tb_da   = da;
    tb_db   = db;
    tick();
    tb_wren = 1'b0;
  endtask

  task automatic rd_pair(input logic [A-1:0] a, output logic [W-1:0] qa, output logic [W-1:0] qb);
    tb_rden = 1'b1;
    tb_ra   = a;
    tb_rb   = a + 1'b1;
    tick();
    tb_rden = 1'b0;
    qa = ram_qa;
    qb = ram_qb;
  endtask

  task automatic clear_upper();
    for (int i = 0; i < 4; i++) wr_pair(A'(8 + 2*i), 8'hEE, 8'hEE);
  endtask

  task automatic check_mem(input string pfx);
    logic [W-1:0] qa, qb;
    for (int i = 0; i < 4; i++) begin
      rd_pair(A'(8 + 2*i), qa, qb);
      chk($sformatf("%s up[%0d]", pfx, 2*i),   32'(qa), 32'(exp_up[2*i]));
      chk($sformatf("%s up[%0d]", pfx, 2*i+1), 32'(qb), 32'(exp_up[2*i+1]));
    end
    for (int i = 0; i < 4; i++) begin
      rd_pair(A'(2*i), qa, qb);
      chk($sformatf("%s lo[%0d]", pfx, 2*i),   32'(qa), 32'(8'h10 + 8'(2*i)));
      chk($sformatf("%s lo[%0d]", pfx, 2*i+1), 32'(qb), 32'(8'h11 + 8'(2*i)));
    end
  endtask

  // Release reset and follow cycles 0..5 of one reorder pass.
  task automatic run_seq(input string pfx);
    rst_n = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      chk($sformatf("%s c%0d rden", pfx, c), 32'(bus.o_rden), 32'(c <= 3));
      chk($sformatf("%s c%0d wren", pfx, c), 32'(bus.o_wren), 32'(c >= 1 && c <= 4));
      chk($sformatf("%s c%0d done", pfx, c), 32'(done),       32'(c == 5));
      if (c <= 3) begin
        chk($sformatf("%s c%0d rdA", pfx, c), 32'(bus.o_rdaddr_A), 32'(2*c));
        chk($sformatf("%s c%0d rdB", pfx, c), 32'(bus.o_rdaddr_B), 32'(2*c+1));
      end
      if (c >= 1 && c <= 4) begin
        chk($sformatf("%s c%0d wrA", pfx, c), 32'(bus.o_wraddr_A), 32'(exp_wa[c-1]));
        chk($sformatf("%s c%0d wrB", pfx, c), 32'(bus.o_wraddr_B), 32'(exp_wb[c-1]));
        chk($sformatf("%s c%0d wdA", pfx, c), 32'(bus.o_wrdata_A), 32'(8'h10 + 8'(2*(c-1))));
        chk($sformatf("%s c%0d wdB", pfx, c), 32'(bus.o_wrdata_B), 32'(8'h11 + 8'(2*(c-1))));
      end
    end
  endtask

  initial begin
`ifdef SCRAMBLE_BYPASS_EN
    exp_up = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    exp_wa = '{8'd8, 8'd10, 8'd12, 8'd14};
    exp_wb = '{8'd9, 8'd11, 8'd13, 8'd15};
`else
    exp_up = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
    exp_wa = '{8'd8, 8'd10, 8'd9, 8'd11};
    exp_wb = '{8'd12, 8'd14, 8'd13, 8'd15};
`endif
    rst_n   = 1'b0;
    tb_mode = 1'b1;
    tb_rden = 1'b0;
    tb_wren = 1'b0;
    tb_ra = '0; tb_rb = '0; tb_wa = '0; tb_wb = '0;
    tb_da = '0; tb_db = '0;

    // Reset held 2 cycles: every output 0.
    tick();
    tick();
    chk("rst rden", 32'(bus.o_rden), 0);
    chk("rst wren", 32'(bus.o_wren), 0);
    chk("rst done", 32'(done), 0);
    chk("rst rdA",  32'(bus.o_rdaddr_A), 0);
    chk("rst rdB",  32'(bus.o_rdaddr_B), 0);
    chk("rst wrA",  32'(bus.o_wraddr_A), 0);
    chk("rst wrB",  32'(bus.o_wraddr_B), 0);
    chk("rst wdA",  32'(bus.o_wrdata_A), 0);
    chk("rst wdB",  32'(bus.o_wrdata_B), 0);

    // Preload lower half 10..17, poison upper half.
    for (int i = 0; i < 4; i++) wr_pair(A'(2*i), 8'h10 + 8'(2*i), 8'h11 + 8'(2*i));
    clear_upper();
    chk("rst wren after preload", 32'(bus.o_wren), 0);

    tb_mode = 1'b0;
    run_seq("run1");

    // Done hold.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("hold%0d done", i), 32'(done), 1);
      chk($sformatf("hold%0d rden", i), 32'(bus.o_rden), 0);
      chk($sformatf("hold%0d wren", i), 32'(bus.o_wren), 0);
    end
    chk("hold wrA", 32'(bus.o_wraddr_A), 32'(exp_wa[3]));
    chk("hold wrB", 32'(bus.o_wraddr_B), 32'(exp_wb[3]));

    tb_mode = 1'b1;
    check_mem("run1");

    // Mid-run reset: re-poison upper half, restart, reset at cycle 2.
    clear_upper();
    rst_n   = 1'b0;
    tb_mode = 1'b0;
    tick();
    chk("mid rst done", 32'(done), 0);
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid c2 rden", 32'(bus.o_rden), 0);
    chk("mid c2 wren", 32'(bus.o_wren), 0);
    chk("mid c2 rdA",  32'(bus.o_rdaddr_A), 0);
    chk("mid c2 wrA",  32'(bus.o_wraddr_A), 0);
    chk("mid c2 done", 32'(done), 0);
    run_seq("rerun");

    tb_mode = 1'b1;
    check_mem("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
